// File: rtl/l2_writeback_buffer.sv
// Write-back buffer between an L2 cache and memory: holds evicted blocks in a small
// circular FIFO, serves read hits from it, coalesces repeat writes and drains when idle.
module l2_writeback_buffer #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8,
  parameter int BLOCK_SIZE = 32,
  parameter int DEPTH      = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [ADDR_WIDTH-1:0]            up_addr,
  input  logic                             up_read,
  input  logic                             up_write,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] up_data_in,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] up_data_out,
  output logic                             up_ready,
  output logic                             up_hit,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic                             mem_read,
  output logic                             mem_write,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_out,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_in,
  input  logic                             mem_ready,
  output logic [$clog2(DEPTH):0]           wb_count,
  output logic                             wb_full,
  output logic                             wb_empty
);

  localparam int BW = BLOCK_SIZE * DATA_WIDTH;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] OFFS_MASK = ADDR_WIDTH'(BLOCK_SIZE - 1);

  typedef enum logic [1:0] {IDLE, RESP, MEM_RD, DRAIN} state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic [BW-1:0]         respData_q, respData_d;
  logic                  hit_q, hit_d;
  logic [ADDR_WIDTH-1:0] rdAddr_q, rdAddr_d;

  logic                  valid_q   [DEPTH];
  logic [ADDR_WIDTH-1:0] entAddr_q [DEPTH];
  logic [BW-1:0]         entData_q [DEPTH];

  logic [ADDR_WIDTH-1:0] reqAlign;
  logic                  matchHit;
  logic [PW-1:0]         matchIdx;
  logic                  wrEn;
  logic [PW-1:0]         wrIdx;
  logic                  invEn;
  logic                  isFull;

  function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign reqAlign = up_addr & ~OFFS_MASK;
  assign isFull   = (count_q == CW'(DEPTH));

  // Coalescing keeps addresses unique, so the first match is the only match.
  always_comb begin
    matchHit = 1'b0;
    matchIdx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!matchHit && valid_q[i] && (entAddr_q[i] == reqAlign)) begin
        matchHit = 1'b1;
        matchIdx = PW'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    respData_d   = respData_q;
    hit_d        = hit_q;
    rdAddr_d     = rdAddr_q;
    wrEn         = 1'b0;
    wrIdx        = tail_q;
    invEn        = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr     = '0;
    mem_data_out = '0;
    unique case (state_q)
      IDLE: begin
        if (up_read) begin
          if (matchHit) begin
            respData_d = entData_q[matchIdx];
            hit_d      = 1'b1;
            state_d    = RESP;
          end else begin
            rdAddr_d = reqAlign;
            state_d  = MEM_RD;
          end
        end else if (up_write) begin
          if (matchHit) begin
            wrEn    = 1'b1;
            wrIdx   = matchIdx;
            hit_d   = 1'b0;
            state_d = RESP;
          end else if (!isFull) begin
            wrEn    = 1'b1;
            wrIdx   = tail_q;
            tail_d  = ptrInc(tail_q);
            count_d = count_q + 1'b1;
            hit_d   = 1'b0;
            state_d = RESP;
          end else begin
            // Full: make room first; the held write is re-sampled afterwards.
            state_d = DRAIN;
          end
        end else if (count_q != '0) begin
          state_d = DRAIN;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        mem_addr = rdAddr_q;
        if (mem_ready) begin
          respData_d = mem_data_in;
          hit_d      = 1'b0;
          state_d    = RESP;
        end
      end
      DRAIN: begin
        mem_write    = 1'b1;
        mem_addr     = entAddr_q[head_q];
        mem_data_out = entData_q[head_q];
        if (mem_ready) begin
          invEn   = 1'b1;
          head_d  = ptrInc(head_q);
          count_d = count_q - 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q    <= IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      respData_q <= '0;
      hit_q      <= 1'b0;
      rdAddr_q   <= '0;
      valid_q    <= '{default: 1'b0};
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      respData_q <= respData_d;
      hit_q      <= hit_d;
      rdAddr_q   <= rdAddr_d;
      if (invEn) valid_q[head_q] <= 1'b0;
      if (wrEn)  valid_q[wrIdx]  <= 1'b1;
    end
  end

  // Payload storage needs no reset: an entry is only visible through its valid bit.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      entAddr_q[wrIdx] <= reqAlign;
      entData_q[wrIdx] <= up_data_in;
    end
  end

  assign up_ready    = (state_q == RESP);
  assign up_hit      = hit_q & (state_q == RESP);
  assign up_data_out = respData_q;
  assign wb_count    = count_q;
  assign wb_full     = isFull;
  assign wb_empty    = (count_q == '0);

endmodule

// File: tb/tb_l2_writeback_buffer.sv
// Scoreboard bench for l2_writeback_buffer: directed requests push expected upstream
// responses and memory transactions; negedge monitors pop and compare them.
module tb_l2_writeback_buffer;

  localparam int AW = 11;
  localparam int DW = 8;
  localparam int BS = 32;
  localparam int DP = 4;
  localparam int BW = BS * DW;
  localparam int CW = $clog2(DP) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] up_addr;
  logic          up_read;
  logic          up_write;
  logic [BW-1:0] up_data_in;
  logic [BW-1:0] up_data_out;
  logic          up_ready;
  logic          up_hit;
  logic [AW-1:0] mem_addr;
  logic          mem_read;
  logic          mem_write;
  logic [BW-1:0] mem_data_out;
  logic [BW-1:0] mem_data_in = '0;
  logic          mem_ready = 1'b0;
  logic [CW-1:0] wb_count;
  logic          wb_full;
  logic          wb_empty;

  l2_writeback_buffer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_SIZE(BS), .DEPTH(DP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .up_addr(up_addr), .up_read(up_read), .up_write(up_write),
    .up_data_in(up_data_in), .up_data_out(up_data_out),
    .up_ready(up_ready), .up_hit(up_hit),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_data_out(mem_data_out), .mem_data_in(mem_data_in), .mem_ready(mem_ready),
    .wb_count(wb_count), .wb_full(wb_full), .wb_empty(wb_empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          hit;
    logic          chk;
    logic          miss;
    logic [BW-1:0] data;
  } upExp_t;

  typedef struct packed {
    logic          isWr;
    logic [AW-1:0] addr;
    logic [BW-1:0] data;
  } memExp_t;

  upExp_t        upQ[$];
  memExp_t       memQ[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            missReadyCyc = -10;
  int            bothHigh = 0;
  int            memLat = 2;
  int            memCnt = 0;
  logic [BW-1:0] memRdData = '0;

  task automatic checkOutput(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void expUp(input logic hit, input logic chk, input logic miss, input logic [BW-1:0] data);
    upExp_t e;
    e.hit = hit; e.chk = chk; e.miss = miss; e.data = data;
    upQ.push_back(e);
  endfunction

  function automatic void expMem(input logic isWr, input logic [AW-1:0] addr, input logic [BW-1:0] data);
    memExp_t e;
    e.isWr = isWr; e.addr = addr; e.data = data;
    memQ.push_back(e);
  endfunction

  always @(posedge clk) cyc++;

  // Memory model: answers a held mem_read/mem_write after memLat cycles with a one-cycle pulse.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      mem_ready = 1'b0;
      memCnt    = 0;
    end else if (mem_ready) begin
      mem_ready = 1'b0;
      memCnt    = 0;
    end else if (mem_read || mem_write) begin
      memCnt++;
      if (memCnt >= memLat) begin
        mem_ready   = 1'b1;
        mem_data_in = memRdData;
      end
    end
  end

  // Upstream monitor: every up_ready pulse consumes one expected response.
  always @(negedge clk) begin
    if (!rst_n && up_ready) begin
      if (upQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedUpReady actual=1 required=0");
      end else begin
        upExp_t e;
        e = upQ.pop_front();
        checkOutput("upHit", up_hit, e.hit);
        if (e.chk) checkOutput("upData", up_data_out, e.data);
        if (e.miss) checkOutput("missLatency", cyc, missReadyCyc + 1);
      end
    end
    if (!rst_n && mem_read && mem_write) bothHigh++;
  end

  // Memory monitor: every completed memory handshake consumes one expected transaction.
  always @(negedge clk) begin
    if (!rst_n && mem_ready && (mem_read || mem_write)) begin
      if (memQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedMemOp actual=%0h required=none", mem_addr);
      end else begin
        memExp_t e;
        e = memQ.pop_front();
        checkOutput("memIsWrite", mem_write, e.isWr);
        checkOutput("memAddr", mem_addr, e.addr);
        if (e.isWr) checkOutput("memWrData", mem_data_out, e.data);
        else missReadyCyc = cyc;
      end
    end
  end

  task automatic waitReady(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!up_ready && n < 200);
    if (!up_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL upReadyTimeout actual=0 required=1");
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [AW-1:0] addr,
                               input logic [BW-1:0] data, output int n);
    up_read    = rd;
    up_write   = wr;
    up_addr    = addr;
    up_data_in = data;
    waitReady(n);
  endtask

  task automatic dropReq();
    up_read  = 1'b0;
    up_write = 1'b0;
  endtask

  task automatic waitEmpty();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(wb_empty && !mem_write && !mem_read) && n < 300);
    if (n >= 300) begin
      checks++;
      errors++;
      $display("[TB] FAIL drainTimeout actual=%0d required=0", wb_count);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [BW-1:0] dA, dB, dC, dD, dE, dW;
    logic [BW-1:0] d0, d1, d2, d3, d4;
    int n;
    dA = {8{32'hA0A1A2A3}};
    dB = {8{32'hB4B5B6B7}};
    dC = {8{32'hC8C9CACB}};
    dD = {8{32'hD0D1D2D3}};
    dE = {8{32'hE4E5E6E7}};
    dW = {8{32'h5A5A0F0F}};
    d0 = {8{32'h00000001}};
    d1 = {8{32'h11111112}};
    d2 = {8{32'h22222223}};
    d3 = {8{32'h33333334}};
    d4 = {8{32'h44444445}};

    rst_n = 1'b1;
    dropReq();
    up_addr    = '0;
    up_data_in = '0;
    repeat (3) @(negedge clk);
    checkOutput("rstUpReady", up_ready, 1'b0);
    checkOutput("rstUpHit", up_hit, 1'b0);
    checkOutput("rstUpData", up_data_out, '0);
    checkOutput("rstMemRead", mem_read, 1'b0);
    checkOutput("rstMemWrite", mem_write, 1'b0);
    checkOutput("rstCount", wb_count, '0);
    checkOutput("rstFull", wb_full, 1'b0);
    checkOutput("rstEmpty", wb_empty, 1'b1);

    // Write then hit-read in a neighbouring offset of the same block.
    rst_n = 1'b0;
    expMem(1'b1, 11'h040, dA);
    expUp(1'b0, 1'b0, 1'b0, '0);
    expUp(1'b1, 1'b1, 1'b0, dA);
    applyStimulus(1'b0, 1'b1, 11'h040, dA, n);
    checkOutput("firstReqLatency", n, 1);
    checkOutput("countAfterWrite", wb_count, 1);
    applyStimulus(1'b1, 1'b0, 11'h05F, '0, n);
    checkOutput("hitLatency", n, 2);
    dropReq();
    waitEmpty();

    // Fill to full, then a fifth write forces the oldest entry out first.
    expMem(1'b1, 11'h000, d0);
    expMem(1'b1, 11'h020, d1);
    expMem(1'b1, 11'h040, d2);
    expMem(1'b1, 11'h060, d3);
    expMem(1'b1, 11'h080, d4);
    for (int i = 0; i < 5; i++) expUp(1'b0, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 11'h000, d0, n);
    applyStimulus(1'b0, 1'b1, 11'h020, d1, n);
    applyStimulus(1'b0, 1'b1, 11'h040, d2, n);
    applyStimulus(1'b0, 1'b1, 11'h060, d3, n);
    checkOutput("fullFlag", wb_full, 1'b1);
    checkOutput("fullCount", wb_count, 4);
    checkOutput("fullNotEmpty", wb_empty, 1'b0);
    applyStimulus(1'b0, 1'b1, 11'h080, d4, n);
    checkOutput("countAfterEvict", wb_count, 4);
    dropReq();
    waitEmpty();

    // Two writes to the same block coalesce; a read of that block sees the newer data.
    expMem(1'b1, 11'h100, dB);
    expUp(1'b0, 1'b0, 1'b0, '0);
    expUp(1'b0, 1'b0, 1'b0, '0);
    expUp(1'b1, 1'b1, 1'b0, dB);
    applyStimulus(1'b0, 1'b1, 11'h100, dA, n);
    applyStimulus(1'b0, 1'b1, 11'h110, dB, n);
    checkOutput("coalesceCount", wb_count, 1);
    applyStimulus(1'b1, 1'b0, 11'h11F, '0, n);
    dropReq();
    waitEmpty();

    // Read miss on an empty buffer goes to memory with a 3-cycle response.
    memLat    = 3;
    memRdData = dC;
    expMem(1'b0, 11'h200, '0);
    expUp(1'b0, 1'b1, 1'b1, dC);
    applyStimulus(1'b1, 1'b0, 11'h200, '0, n);
    checkOutput("missCount", wb_count, '0);
    dropReq();
    waitEmpty();
    memLat = 2;

    // Simultaneous read and write: the read is served first, the write afterwards.
    memRdData = dD;
    expMem(1'b0, 11'h300, '0);
    expMem(1'b1, 11'h300, dW);
    expUp(1'b0, 1'b1, 1'b1, dD);
    expUp(1'b0, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b1, 11'h300, dW, n);
    checkOutput("writeStillPending", wb_count, '0);
    up_read = 1'b0;
    waitReady(n);
    checkOutput("pendingWriteAccepted", wb_count, 1);
    dropReq();
    waitEmpty();

    // Reset in the middle of a slow drain abandons it; the entry is never written.
    memLat = 20;
    expUp(1'b0, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 11'h400, dE, n);
    dropReq();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_write && n < 20);
    checkOutput("drainStarted", mem_write, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rstMidDrainMemWrite", mem_write, 1'b0);
    checkOutput("rstMidDrainCount", wb_count, '0);
    checkOutput("rstMidDrainEmpty", wb_empty, 1'b1);
    repeat (3) @(negedge clk);
    rst_n  = 1'b0;
    memLat = 2;
    repeat (30) @(negedge clk);
    checkOutput("postRstEmpty", wb_empty, 1'b1);
    checkOutput("postRstMemWrite", mem_write, 1'b0);

    checkOutput("upQueueDrained", upQ.size(), 0);
    checkOutput("memQueueDrained", memQ.size(), 0);
    checkOutput("memRdWrExclusive", bothHigh, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/l2_writeback_buffer.md
L2_WRITEBACK_BUFFER -- requirements
Module: l2_writeback_buffer

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 11, meaning byte address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, meaning bits per byte lane.
REQ-003 The block SHALL have parameter BLOCK_SIZE, default 32, meaning bytes per L2 block (power of 2).
REQ-004 The block SHALL have parameter DEPTH, default 4, meaning buffered write-back entries (power of 2).
REQ-005 The block SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-006 The block SHALL have port rst_n  input  1  reset, asynchronous, active-high; clock clk.
REQ-007 The block SHALL have port up_addr  input  ADDR_WIDTH  L2-side request address.
REQ-008 The block SHALL have port up_read  input  1  L2 block read request, level, held until up_ready.
REQ-009 The block SHALL have port up_write  input  1  L2 block write-back request, level, held until up_ready.
REQ-010 The block SHALL have port up_data_in  input  BLOCK_SIZE*DATA_WIDTH  write-back block data.
REQ-011 The block SHALL have port up_data_out  output  BLOCK_SIZE*DATA_WIDTH  read response block.
REQ-012 The block SHALL have port up_ready  output  1  one-cycle completion pulse to L2.
REQ-013 The block SHALL have port up_hit  output  1  read served from buffer, valid with up_ready.
REQ-014 The block SHALL have ports mem_addr  output  ADDR_WIDTH; mem_read, mem_write  output  1; mem_data_out  output  BLOCK_SIZE*DATA_WIDTH; mem_data_in  input  BLOCK_SIZE*DATA_WIDTH; mem_ready  input  1 (memory-side, mem_read/mem_write held until mem_ready pulse).
REQ-015 The block SHALL have ports wb_count  output  log2(DEPTH)+1  occupied entries; wb_full, wb_empty  output  1.

Function
REQ-016 The block SHALL align every stored or issued address by clearing the low log2(BLOCK_SIZE) bits.
REQ-017 The block SHALL hold entries in a circular FIFO (head/tail pointers wrap modulo DEPTH), each entry = valid, aligned address, block data.
REQ-018 The FSM SHALL have states IDLE, RESP, MEM_RD, DRAIN; only IDLE samples upstream requests.
REQ-019 IDLE with up_read high SHALL win over up_write high in the same cycle; the write stays pending.
REQ-020 Write in IDLE, aligned address matching a valid entry: that entry's data SHALL be overwritten (coalesce), count unchanged, go RESP.
REQ-021 Write in IDLE, no match, not full: data SHALL be stored at tail, tail+1, count+1, go RESP.
REQ-022 Write in IDLE, no match, full: SHALL go DRAIN without accepting; write accepted after drain returns to IDLE.
REQ-023 Read in IDLE matching a valid entry: up_data_out SHALL be that entry's data, go RESP with up_hit=1.
REQ-024 Read in IDLE, no match: SHALL go MEM_RD, drive mem_read=1 with aligned address until mem_ready; capture mem_data_in, go RESP with up_hit=0.
REQ-025 RESP SHALL assert up_ready for exactly one cycle then return to IDLE; accepted write/hit-read latency = 1 cycle after sampling, miss latency = memory latency + 1.
REQ-026 IDLE with no request and count>0 SHALL go DRAIN: mem_write=1, mem_addr/mem_data_out = head entry until mem_ready; then invalidate head, head+1, count-1, go IDLE.
REQ-027 DRAIN and MEM_RD SHALL be non-preemptible; upstream requests wait with up_ready low.
REQ-028 mem_read and mem_write SHALL never be high simultaneously.
REQ-029 wb_full SHALL equal (count==DEPTH); wb_empty SHALL equal (count==0).

Reset
REQ-030 While rst_n is high the block SHALL clear all valid bits, pointers, count, state=IDLE, all outputs 0 except wb_empty=1, abandoning any in-flight memory transaction.
REQ-031 After rst_n falls, the first request SHALL be sampled on the next rising edge.

Verification
REQ-032 Write 0x040 data A, then read 0x05F -> up_ready 1 cycle after read sampled, up_hit=1, up_data_out=A, no mem_read.
REQ-033 Writes 0x000,0x020,0x040,0x060 then write 0x080 -> wb_full=1, head 0x000 drained via mem_write, then 0x080 accepted, wb_count=4.
REQ-034 Write 0x100 data A, write 0x110 data B -> coalesced, wb_count=1, later drain writes B to 0x100.
REQ-035 Read 0x200 (empty buffer), memory returns C after 3 cycles -> mem_read at 0x200, up_ready 1 cycle after mem_ready, up_hit=0, up_data_out=C.
REQ-036 up_read and up_write high together at 0x300 -> read served first, write accepted afterward.
REQ-037 Assert rst_n during DRAIN -> mem_write=0 immediately, wb_count=0, wb_empty=1, no entry written later.
